ikili_kilit_kontrol: RTL

Sequential front-end that sits directly upstream of the dual combination lock evaluator (ikili_kilit) and drives its sag_adimlar, sol_adimlar and kilit_sifreler inputs.
- Turns raw right/left/next button levels into per-lock step counts.
- Stores the two 6-bit passwords.
- Samples the evaluator's kilitler_acik result on submit.
- Manages the open, failed-attempt and lockout states.

---
 rtl/ikili_kilit_pkg.sv | 16 +
 rtl/ikili_kilit_kontrol_if.sv | 27 ++
 rtl/ikili_kilit_kontrol_kenar_algilayici.sv | 15 +
 rtl/ikili_kilit_kontrol.sv | 115 +++++++++++
 4 files changed

// File: rtl/ikili_kilit_pkg.sv
// ikili_kilit_pkg: shared state encoding and field widths for the dual-lock front-end
package ikili_kilit_pkg;
    typedef enum logic [2:0] {
        BOSTA   = 3'd0,
        GIRIS1  = 3'd1,
        GIRIS0  = 3'd2,
        KONTROL = 3'd3,
        ACIK    = 3'd4,
        KILITLI = 3'd5
    } durum_t;

    localparam int SAG_W   = 3;
    localparam int SOL_W   = 2;
    localparam int SIFRE_W = 6;
    localparam logic [SIFRE_W-1:0] SIFRE_MAX = 6'd39;
endpackage

// File: rtl/ikili_kilit_kontrol_if.sv
// ikili_kilit_kontrol_if: buttons, password port and evaluator-facing outputs of the lock front-end
interface ikili_kilit_kontrol_if;
    import ikili_kilit_pkg::*;
    logic                   sag_dugme;
    logic                   sol_dugme;
    logic                   sonraki_dugme;
    logic                   sifre_yukle;
    logic                   sifre_indeks;
    logic [SIFRE_W-1:0]     sifre_veri;
    logic                   kilitler_acik;
    logic [2*SAG_W-1:0]     sag_adimlar;
    logic [2*SOL_W-1:0]     sol_adimlar;
    logic [2*SIFRE_W-1:0]   kilit_sifreler;
    logic                   acik;
    logic                   kilitli;
    logic                   sifre_hata;
    logic [2:0]             hata_sayisi;

    modport master (
        output sag_dugme, sol_dugme, sonraki_dugme, sifre_yukle, sifre_indeks, sifre_veri, kilitler_acik,
        input  sag_adimlar, sol_adimlar, kilit_sifreler, acik, kilitli, sifre_hata, hata_sayisi
    );
    modport slave (
        input  sag_dugme, sol_dugme, sonraki_dugme, sifre_yukle, sifre_indeks, sifre_veri, kilitler_acik,
        output sag_adimlar, sol_adimlar, kilit_sifreler, acik, kilitli, sifre_hata, hata_sayisi
    );
endinterface

// File: rtl/ikili_kilit_kontrol_kenar_algilayici.sv
// kenar_algilayici: rising-edge detector; history resets to 1 so a level held through reset gives no edge
module kenar_algilayici (
    input  logic clk,
    input  logic rst_n,
    input  logic seviye,
    output logic kenar
);
    logic onceki;

    always_ff @(posedge clk) begin
        onceki <= !rst_n ? 1'b1 : seviye;
    end

    assign kenar = seviye & ~onceki;
endmodule

// File: rtl/ikili_kilit_kontrol.sv
// ikili_kilit_kontrol: turns button presses into per-lock step counts, stores passwords,
// and tracks open / failed-attempt / lockout state around the dual-lock evaluator
module ikili_kilit_kontrol
    import ikili_kilit_pkg::*;
#(
    parameter int HATA_LIMIT     = 3,
    parameter int BEKLEME_CEVRIM = 16
) (
    input logic                  clk,
    input logic                  rst_n,
    ikili_kilit_kontrol_if.slave kk
);
    localparam int SW = $clog2(BEKLEME_CEVRIM) + 1;
    localparam logic [SW-1:0] SAYAC_SON = SW'(BEKLEME_CEVRIM - 1);
    localparam logic [2:0]    LIMIT     = 3'(HATA_LIMIT);

    durum_t durum, durum_n;
    logic [SAG_W-1:0]   sag_ust, sag_alt, sag_ust_n, sag_alt_n;
    logic [SOL_W-1:0]   sol_ust, sol_alt, sol_ust_n, sol_alt_n;
    logic [SIFRE_W-1:0] sifre_ust, sifre_alt;
    logic [2:0]         hata, hata_n;
    logic [SW-1:0]      sayac, sayac_n;
    logic               sifre_hata;
    logic               sag_k, sol_k, sonraki_k;
    logic               sag_adim, sol_adim, temizle, yaz, gecerli;

    kenar_algilayici u_sag     (.clk(clk), .rst_n(rst_n), .seviye(kk.sag_dugme),     .kenar(sag_k));
    kenar_algilayici u_sol     (.clk(clk), .rst_n(rst_n), .seviye(kk.sol_dugme),     .kenar(sol_k));
    kenar_algilayici u_sonraki (.clk(clk), .rst_n(rst_n), .seviye(kk.sonraki_dugme), .kenar(sonraki_k));

    // a step that coincides with submit/advance is dropped
    assign sag_adim = sag_k & ~sonraki_k;
    assign sol_adim = sol_k & ~sonraki_k;
    assign yaz      = (durum == BOSTA) & kk.sifre_yukle;
    assign gecerli  = kk.sifre_veri <= SIFRE_MAX;

    always_comb begin
        durum_n   = durum;
        sag_ust_n = sag_ust;
        sag_alt_n = sag_alt;
        sol_ust_n = sol_ust;
        sol_alt_n = sol_alt;
        hata_n    = hata;
        sayac_n   = '0;
        temizle   = 1'b0;
        case (durum)
            BOSTA: durum_n = sonraki_k ? GIRIS1 : BOSTA;
            GIRIS1: begin
                durum_n   = sonraki_k ? GIRIS0 : GIRIS1;
                sag_ust_n = sag_adim ? sag_ust + SAG_W'(1) : sag_ust;
                sol_ust_n = sol_adim ? sol_ust + SOL_W'(1) : sol_ust;
            end
            GIRIS0: begin
                durum_n   = sonraki_k ? KONTROL : GIRIS0;
                sag_alt_n = sag_adim ? sag_alt + SAG_W'(1) : sag_alt;
                sol_alt_n = sol_adim ? sol_alt + SOL_W'(1) : sol_alt;
            end
            KONTROL: begin
                hata_n  = kk.kilitler_acik ? 3'd0 : hata + 3'd1;
                durum_n = kk.kilitler_acik ? ACIK : (hata_n == LIMIT) ? KILITLI : GIRIS1;
                temizle = ~kk.kilitler_acik;
            end
            ACIK: begin
                durum_n = sonraki_k ? BOSTA : ACIK;
                temizle = sonraki_k;
            end
            KILITLI: begin
                durum_n = (sayac == SAYAC_SON) ? BOSTA : KILITLI;
                sayac_n = (sayac == SAYAC_SON) ? '0 : sayac + SW'(1);
                hata_n  = (sayac == SAYAC_SON) ? 3'd0 : hata;
            end
            default: durum_n = BOSTA;
        endcase
        if (temizle) begin
            sag_ust_n = '0;
            sag_alt_n = '0;
            sol_ust_n = '0;
            sol_alt_n = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            durum      <= BOSTA;
            sag_ust    <= '0;
            sag_alt    <= '0;
            sol_ust    <= '0;
            sol_alt    <= '0;
            hata       <= '0;
            sayac      <= '0;
            sifre_ust  <= '0;
            sifre_alt  <= '0;
            sifre_hata <= 1'b0;
        end else begin
            durum      <= durum_n;
            sag_ust    <= sag_ust_n;
            sag_alt    <= sag_alt_n;
            sol_ust    <= sol_ust_n;
            sol_alt    <= sol_alt_n;
            hata       <= hata_n;
            sayac      <= sayac_n;
            sifre_hata <= yaz & ~gecerli;
            if (yaz & gecerli & kk.sifre_indeks)  sifre_ust <= kk.sifre_veri;
            if (yaz & gecerli & ~kk.sifre_indeks) sifre_alt <= kk.sifre_veri;
        end
    end

    assign kk.sag_adimlar    = {sag_ust, sag_alt};
    assign kk.sol_adimlar    = {sol_ust, sol_alt};
    assign kk.kilit_sifreler = {sifre_ust, sifre_alt};
    assign kk.acik           = durum == ACIK;
    assign kk.kilitli        = durum == KILITLI;
    assign kk.sifre_hata     = sifre_hata;
    assign kk.hata_sayisi    = hata;
endmodule
